// File: rtl/aes_round_sched.sv
// AES-128 iterative round sequencer: LOAD, NR rounds, DONE, with Rcon generation.
// Optional build macro: DEC_EN adds a 'dec' input that selects a descending Rcon sequence.
module aes_round_sched #(
    parameter int unsigned NR = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       stall,
`ifdef DEC_EN
    input  logic       dec,
`endif
    output logic       ready,
    output logic       busy,
    output logic       data_load,
    output logic       round_en,
    output logic       first_rnd,
    output logic       final_rnd,
    output logic [3:0] rnd_idx,
    output logic [7:0] rcon,
    output logic       done
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned RCON_W = 8;

    localparam logic [IDX_W-1:0]  NR_IDX    = IDX_W'(NR);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [RCON_W-1:0] RCON_ENC0 = 8'h01;
    localparam logic [RCON_W-1:0] RCON_DEC0 = 8'h36;
    localparam logic [RCON_W-1:0] POLY      = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rnd_idx_q, rnd_idx_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic                dec_q, dec_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                data_load_q, data_load_d;
    logic                round_en_q, round_en_d;
    logic                first_rnd_q, first_rnd_d;
    logic                final_rnd_q, final_rnd_d;
    logic                done_q, done_d;
    logic                hold_c;
    logic                start_dec_c;

    // Direction requested with the start handshake (encrypt-only without DEC_EN).
`ifdef DEC_EN
    assign start_dec_c = dec;
`else
    assign start_dec_c = 1'b0;
`endif

    // One key-schedule Rcon step: xtime forward, inverse xtime for decrypt.
    function automatic logic [RCON_W-1:0] rcon_step(input logic [RCON_W-1:0] r,
                                                    input logic             inv);
        logic [RCON_W-1:0] res;
        if (inv) begin
            res = r[0] ? (((r ^ POLY) >> 1) | 8'h80) : (r >> 1);
        end else begin
            res = {r[RCON_W-2:0], 1'b0} ^ (r[RCON_W-1] ? POLY : 8'h00);
        end
        return res;
    endfunction

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        rnd_idx_d = rnd_idx_q;
        rcon_d    = rcon_q;
        dec_d     = dec_q;
        hold_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    rnd_idx_d = '0;
                    dec_d     = start_dec_c;
                    rcon_d    = start_dec_c ? RCON_DEC0 : '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    rnd_idx_d = '0;
                    rcon_d    = '0;
                end else if (stall) begin
                    hold_c = 1'b1;
                end else begin
                    state_d   = ST_ROUND;
                    rnd_idx_d = IDX_ONE;
                    rcon_d    = dec_q ? RCON_DEC0 : RCON_ENC0;
                end
            end
            ST_ROUND: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    rnd_idx_d = '0;
                    rcon_d    = '0;
                end else if (stall) begin
                    hold_c = 1'b1;
                end else if (rnd_idx_q == NR_IDX) begin
                    // rnd_idx keeps NR through DONE
                    state_d = ST_DONE;
                    rcon_d  = '0;
                end else begin
                    rnd_idx_d = rnd_idx_q + IDX_ONE;
                    rcon_d    = rcon_step(rcon_q, dec_q);
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                rnd_idx_d = '0;
                rcon_d    = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                rnd_idx_d = '0;
                rcon_d    = '0;
            end
        endcase

        // Strobes describe the cycle that follows this edge; a held cycle does no work.
        ready_d     = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        data_load_d = (state_d == ST_LOAD) && !hold_c;
        round_en_d  = (state_d == ST_ROUND) && !hold_c;
        first_rnd_d = (state_d == ST_ROUND) && (rnd_idx_d == IDX_ONE);
        final_rnd_d = (state_d == ST_ROUND) && (rnd_idx_d == NR_IDX);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_idx_q   <= '0;
            rcon_q      <= '0;
            dec_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            data_load_q <= 1'b0;
            round_en_q  <= 1'b0;
            first_rnd_q <= 1'b0;
            final_rnd_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_idx_q   <= rnd_idx_d;
            rcon_q      <= rcon_d;
            dec_q       <= dec_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            data_load_q <= data_load_d;
            round_en_q  <= round_en_d;
            first_rnd_q <= first_rnd_d;
            final_rnd_q <= final_rnd_d;
            done_q      <= done_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign data_load = data_load_q;
    assign round_en  = round_en_q;
    assign first_rnd = first_rnd_q;
    assign final_rnd = final_rnd_q;
    assign rnd_idx   = rnd_idx_q;
    assign rcon      = rcon_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Scoreboard bench for aes_round_sched: driver pushes expected events, monitor pops and compares.
module tb_aes_round_sched;

    localparam int NR = 10;

    typedef struct {
        int cyc;
        int idx;
        int rc;
        int first;
        int fin;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, stall;
    logic       dec;
    logic       ready, busy, data_load, round_en, first_rnd, final_rnd, done;
    logic [3:0] rnd_idx;
    logic [7:0] rcon;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    exp_t lq[$];
    exp_t rq[$];
    int   dq[$];

    // Key-schedule round constants for rounds 1..10 (index 0 unused).
    int enc_tbl[0:10] = '{0, 'h01, 'h02, 'h04, 'h08, 'h10, 'h20, 'h40, 'h80, 'h1b, 'h36};
    int dec_tbl[0:10] = '{0, 'h36, 'h1b, 'h80, 'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01};

    aes_round_sched #(.NR(NR)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .stall     (stall),
`ifdef DEC_EN
        .dec       (dec),
`endif
        .ready     (ready),
        .busy      (busy),
        .data_load (data_load),
        .round_en  (round_en),
        .first_rnd (first_rnd),
        .final_rnd (final_rnd),
        .rnd_idx   (rnd_idx),
        .rcon      (rcon),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rc_of(input int r, input bit d);
        return d ? dec_tbl[r] : enc_tbl[r];
    endfunction

    // Monitor: every strobe the DUT presents must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        int   dc;
        if (rst_n === 1'b1) begin
            if (data_load === 1'b1) begin
                chk("load_expected", 32'(lq.size() != 0), 1);
                if (lq.size() != 0) begin
                    e = lq.pop_front();
                    chk("load_cycle", cyc, e.cyc);
                    chk("load_idx", 32'(rnd_idx), e.idx);
                    chk("load_rcon", 32'(rcon), e.rc);
                end
            end
            if (round_en === 1'b1) begin
                chk("round_expected", 32'(rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    e = rq.pop_front();
                    chk("round_cycle", cyc, e.cyc);
                    chk("round_idx", 32'(rnd_idx), e.idx);
                    chk("round_rcon", 32'(rcon), e.rc);
                    chk("round_first", 32'(first_rnd), e.first);
                    chk("round_final", 32'(final_rnd), e.fin);
                end
            end
            if (done === 1'b1) begin
                chk("done_expected", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    dc = dq.pop_front();
                    chk("done_cycle", cyc, dc);
                    chk("done_idx", 32'(rnd_idx), NR);
                    chk("done_rcon", 32'(rcon), 0);
                    chk("done_busy", 32'(busy), 1);
                end
            end
        end
    end

    // One block from IDLE. s>=0: stall for len edges after round s (s=0: in LOAD).
    // k>=0: abort right after round k (k=0: in LOAD). spam: hold start high while busy.
    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic run_block(input int s, input int len, input int k, input bit dec_b,
                             input bit spam);
        exp_t e;
        int   a, last, nlast, l;
        l = (s >= 0) ? len : 0;
        chk("ready_before_start", 32'(ready), 1);
        a = cyc + 1;
        e.cyc = a; e.idx = 0; e.rc = dec_b ? 'h36 : 0; e.first = 0; e.fin = 0;
        lq.push_back(e);
        nlast = (k >= 0) ? k : NR;
        for (int r = 1; r <= nlast; r++) begin
            e.cyc   = a + r + ((s >= 0 && r > s) ? l : 0);
            e.idx   = r;
            e.rc    = rc_of(r, dec_b);
            e.first = (r == 1) ? 1 : 0;
            e.fin   = (r == NR) ? 1 : 0;
            rq.push_back(e);
        end
        if (k < 0) dq.push_back(a + NR + 1 + l);
        last = (k >= 0) ? a + k + 1 : a + NR + 2 + l;
        for (int ed = a; ed <= last; ed++) begin
            start = (ed == a) || (spam && ed > a);
            stall = (s >= 0 && ed > a + s && ed <= a + s + l);
            abort = (k >= 0 && ed == last);
            dec   = (ed == a) ? dec_b : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (s >= 1 && cyc > a + s && cyc <= a + s + l) begin
                chk("stall_idx", 32'(rnd_idx), s);
                chk("stall_rcon", 32'(rcon), rc_of(s, dec_b));
                chk("stall_round_en", 32'(round_en), 0);
                chk("stall_final", 32'(final_rnd), (s == NR) ? 1 : 0);
            end
            if (cyc == last) begin
                chk("idle_ready", 32'(ready), 1);
                chk("idle_busy", 32'(busy), 0);
                chk("idle_idx", 32'(rnd_idx), 0);
                chk("idle_rcon", 32'(rcon), 0);
                chk("idle_done", 32'(done), 0);
            end
        end
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        chk("load_q_drained", lq.size(), 0);
        chk("round_q_drained", rq.size(), 0);
        chk("done_q_drained", dq.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_load"}, 32'(data_load), 0);
        chk({tag, "_round_en"}, 32'(round_en), 0);
        chk({tag, "_first"}, 32'(first_rnd), 0);
        chk({tag, "_final"}, 32'(final_rnd), 0);
        chk({tag, "_idx"}, 32'(rnd_idx), 0);
        chk({tag, "_rcon"}, 32'(rcon), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Async reset while round 7 is in progress; no done may follow.
    task automatic mid_reset();
        exp_t e;
        int   a;
        a = cyc + 1;
        e.cyc = a; e.idx = 0; e.rc = 0; e.first = 0; e.fin = 0;
        lq.push_back(e);
        for (int r = 1; r <= 7; r++) begin
            e.cyc = a + r; e.idx = r; e.rc = enc_tbl[r];
            e.first = (r == 1) ? 1 : 0; e.fin = (r == NR) ? 1 : 0;
            rq.push_back(e);
        end
        start = 1'b1;
        dec   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc < a + 7; i++) @(negedge clk);
        chk("pre_reset_idx", 32'(rnd_idx), 7);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 1);
        chk("rst_round_q", rq.size(), 0);
        chk("rst_done_q", dq.size(), 0);
    endtask

    initial begin
        int kind, s, len, k;
        bit d, sp;
        start = 1'b0;
        abort = 1'b0;
        stall = 1'b0;
        dec   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_block(-1, 0, -1, 1'b0, 1'b0);   // plain block
        run_block(4, 3, -1, 1'b0, 1'b0);    // stall 3 cycles at round 4
        run_block(-1, 0, 6, 1'b0, 1'b0);    // abort at round 6
        run_block(-1, 0, -1, 1'b0, 1'b0);   // normal block right after abort
        run_block(-1, 0, -1, 1'b0, 1'b1);   // start held high throughout, incl. DONE
        run_block(0, 2, -1, 1'b0, 1'b0);    // stall in LOAD
        run_block(NR, 2, -1, 1'b0, 1'b0);   // stall after final round
        run_block(-1, 0, 0, 1'b0, 1'b0);    // abort in LOAD
`ifdef DEC_EN
        run_block(-1, 0, -1, 1'b1, 1'b0);   // decrypt Rcon sequence
        run_block(5, 2, -1, 1'b1, 1'b1);
`endif
        mid_reset();
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            s    = (kind == 1) ? $urandom_range(0, NR) : -1;
            len  = $urandom_range(1, 4);
            k    = (kind == 2) ? $urandom_range(0, NR) : -1;
            sp   = 1'($urandom_range(0, 1));
`ifdef DEC_EN
            d    = 1'($urandom_range(0, 1));
`else
            d    = 1'b0;
`endif
            run_block(s, len, k, d, sp);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sched.md
Name: aes_round_sched

Overview:
Round sequencer for the AES-128 iterative datapath. It accepts a start handshake and sequences the initial load/AddRoundKey cycle, NR round cycles and a completion cycle. It generates the per-round round constant (Rcon), the first-round and final-round flags, and the load and enable strobes for the state and key registers. It sits between the host/bus interface and the round datapath plus key expansion logic.

Parameters:
NR, 10, number of cipher rounds; legal range 1..10; rnd_idx is 4 bits wide.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin a block; accepted only when ready=1
abort  input  1  synchronous abort; returns to IDLE next cycle
stall  input  1  freezes sequencing in LOAD/ROUND
ready  output  1  high in IDLE; start accepted when start&ready
busy  output  1  high in LOAD, ROUND and DONE
data_load  output  1  load plaintext/key and do the initial AddRoundKey (LOAD only)
round_en  output  1  enable state and round-key registers (ROUND, not stalled)
first_rnd  output  1  high when rnd_idx==1 in ROUND
final_rnd  output  1  high when rnd_idx==NR in ROUND (skip MixColumns)
rnd_idx  output  4  current round number
rcon  output  8  round constant for current round key expansion
done  output  1  one-cycle pulse; datapath result valid

Behaviour:
- Reset (rst_n low, async): state=IDLE, rnd_idx=0, rcon=8'h00, ready=1, busy=0, all strobes and flags 0. Release is synchronous to clk.
- States: IDLE -> LOAD -> ROUND -> DONE -> IDLE.
- IDLE: ready=1. start=1 at edge T -> LOAD at T+1. start while not IDLE is ignored (not queued).
- LOAD, one cycle: data_load=1, rnd_idx=0, rcon=8'h00. Next is ROUND with rnd_idx=1 and rcon=8'h01.
- ROUND: round_en=1.
  - rcon update each advance: rcon_next = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - Sequence for rnd_idx 1..10 is 01,02,04,08,10,20,40,80,1b,36.
  - rnd_idx increments per advance. When rnd_idx==NR, the next state is DONE.
- DONE, one cycle: done=1, busy=1, rcon=8'h00, rnd_idx holds NR. Next is IDLE.
- Latency without stall: start accepted at T; LOAD at T+1; rounds at T+2..T+NR+1; done at T+NR+2. With NR=10, done is at T+12, and start is next accepted at T+13.
- stall=1 in LOAD or ROUND:
  - state, rnd_idx and rcon hold.
  - data_load and round_en are forced 0.
  - first_rnd and final_rnd keep their values.
- stall has no effect in IDLE or DONE. DONE always lasts exactly one cycle.
- abort=1 in any non-IDLE state: next cycle is IDLE with rnd_idx=0, rcon=00, no done pulse.
- abort has priority over stall. abort together with start in IDLE: start wins.
- Async reset mid-operation: immediate return to reset values, no done.
- NR=1: first_rnd and final_rnd are both high in the single ROUND cycle.

Optional Feature:
DEC_EN:
- Defined: adds input port dec (1 bit), sampled on start acceptance and held for the block.
- With dec=1:
  - LOAD presents rcon=8'h36, then the first ROUND cycle uses 36.
  - Each advance applies the inverse xtime: rcon_next = rcon[0] ? (((rcon ^ 8'h1b) >> 1) | 8'h80) : (rcon >> 1).
  - Sequence is 36,1b,80,40,20,10,08,04,02,01.
  - rnd_idx, first_rnd and final_rnd are unchanged (ascending).
- Not defined: no dec port; encrypt-only sequencing as above.

Test Plan:
- Reset, then start pulse with NR=10: data_load at T+1; round_en T+2..T+11; rcon 01..36 in order; first_rnd at T+2; final_rnd at T+11; done at T+12; ready=1 at T+13.
- stall high 3 cycles while rnd_idx=4: rnd_idx=4 and rcon=08 hold, round_en=0 for those cycles, then resume; done at T+15.
- abort at rnd_idx=6: next cycle IDLE with ready=1, rcon=00, no done pulse; new start completes normally.
- start pulsed at rnd_idx=3 and during DONE: ignored; exactly one done per accepted start.
- rst_n asserted low mid-ROUND (rnd_idx=7): outputs reach reset values without waiting for clk; after release, ready=1.
- DEC_EN defined, dec=1: rcon sequence 36,1b,80,40,20,10,08,04,02,01 across rnd_idx 1..10; done at T+12.
